// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and element helpers for the matrix-multiply core.
// Operand rows hold MAX_DIM signed elements; result rows hold MAX_DIM double-width elements.
package matmul_pkg;

    localparam int DATA_W    = 16;
    localparam int BUS_W     = 64;
    localparam int ADDR_W    = 2;
    localparam int MAX_DIM   = BUS_W / DATA_W;
    localparam int DIM_W     = $clog2(MAX_DIM);
    localparam int OUT_W     = 2 * DATA_W;
    localparam int OUT_BUS_W = 2 * BUS_W;
    localparam int ACC_W     = OUT_W + DIM_W + 1;
    localparam int SAT_W     = MAX_DIM * MAX_DIM;

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = {{(ACC_W-OUT_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = {{(ACC_W-OUT_W){1'b1}}, SAT_MIN};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    function automatic logic [DATA_W-1:0] get_elem(input logic [BUS_W-1:0] row, input int j);
        return row[j*DATA_W +: DATA_W];
    endfunction

    function automatic logic [OUT_W-1:0] get_out_elem(input logic [OUT_BUS_W-1:0] row, input int j);
        return row[j*OUT_W +: OUT_W];
    endfunction

    function automatic logic signed [ACC_W-1:0] out_ext(input logic [OUT_W-1:0] v);
        return {{(ACC_W-OUT_W){v[OUT_W-1]}}, v};
    endfunction

    // Both factors are widened before multiplying so the product is exact in OUT_W bits.
    function automatic logic signed [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b);
        logic signed [OUT_W-1:0] sa;
        logic signed [OUT_W-1:0] sb;
        logic signed [OUT_W-1:0] p;
        sa = {{DATA_W{a[DATA_W-1]}}, a};
        sb = {{DATA_W{b[DATA_W-1]}}, b};
        p  = sa * sb;
        return out_ext(p);
    endfunction

endpackage

// File: rtl/matmul_mac_row.sv
// MAX_DIM parallel signed MAC lanes sharing one A element, with a saturating output stage.
// The accumulators are wide enough that a full row sum plus an old C value never wraps.
module matmul_mac_row
    import matmul_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [DATA_W-1:0]    i_a,
    input  logic [BUS_W-1:0]     i_b_row,
    input  logic [OUT_BUS_W-1:0] i_c_row,
    output logic [OUT_BUS_W-1:0] o_row,
    output logic [MAX_DIM-1:0]   o_ovf
);

    logic signed [ACC_W-1:0] r_acc [MAX_DIM];

    always_ff @(posedge clk_i) begin
        for (int j = 0; j < MAX_DIM; j++) begin
            if (!reset_ni || i_clear) begin
                r_acc[j] <= '0;
            end else if (i_load) begin
                r_acc[j] <= out_ext(get_out_elem(i_c_row, j));
            end else if (i_step) begin
                r_acc[j] <= r_acc[j] + mul_ext(i_a, get_elem(i_b_row, j));
            end
        end
    end

    always_comb begin
        o_row = '0;
        o_ovf = '0;
        for (int j = 0; j < MAX_DIM; j++) begin
            if (r_acc[j] > ACC_SAT_MAX) begin
                o_row[j*OUT_W +: OUT_W] = SAT_MAX;
                o_ovf[j]                = 1'b1;
            end else if (r_acc[j] < ACC_SAT_MIN) begin
                o_row[j*OUT_W +: OUT_W] = SAT_MIN;
                o_ovf[j]                = 1'b1;
            end else begin
                o_row[j*OUT_W +: OUT_W] = r_acc[j][OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/matmul_core.sv
// Row-at-a-time matrix multiply controller: reads A row i, streams B rows k, writes C row i.
// Strobe/address outputs are decoded from the state register, so they are zero outside their state.
module matmul_core
    import matmul_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic                 acc_i,
    input  logic [DIM_W-1:0]     n_dim_i,
    input  logic [DIM_W-1:0]     k_dim_i,
    input  logic [DIM_W-1:0]     m_dim_i,
    output logic [ADDR_W-1:0]    a_addr_o,
    output logic [ADDR_W-1:0]    b_addr_o,
    output logic [ADDR_W-1:0]    c_raddr_o,
    output logic                 a_rd_o,
    output logic                 b_rd_o,
    output logic                 c_rd_o,
    input  logic [BUS_W-1:0]     a_data_i,
    input  logic [BUS_W-1:0]     b_data_i,
    input  logic [OUT_BUS_W-1:0] c_rdata_i,
    output logic                 c_wr_o,
    output logic [ADDR_W-1:0]    c_waddr_o,
    output logic [OUT_BUS_W-1:0] c_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [SAT_W-1:0]     sat_o,
    output state_e               dbg_state_o
);

    state_e                 r_state;
    state_e                 w_next;
    logic [DIM_W-1:0]       r_n;
    logic [DIM_W-1:0]       r_k_dim;
    logic [DIM_W-1:0]       r_m;
    logic [DIM_W-1:0]       r_i;
    logic [DIM_W-1:0]       r_k;
    logic                   r_acc;
    logic [SAT_W-1:0]       r_sat;
    logic [BUS_W-1:0]       r_a_row;
    logic                   w_clear;
    logic                   w_load;
    logic                   w_step;
    logic [OUT_BUS_W-1:0]   w_row;
    logic [MAX_DIM-1:0]     w_ovf;
    logic [SAT_W-1:0]       w_sat_set;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_k_dim <= '0;
            r_m     <= '0;
            r_i     <= '0;
            r_k     <= '0;
            r_acc   <= 1'b0;
            r_sat   <= '0;
            r_a_row <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_n     <= n_dim_i;
                    r_k_dim <= k_dim_i;
                    r_m     <= m_dim_i;
                    r_acc   <= acc_i;
                    r_sat   <= '0;
                    r_i     <= '0;
                end
                S_RD_A: r_k <= '0;
                S_MAC: begin
                    r_k <= r_k + DIM_W'(1);
                    // The A row is captured once, then shifted so lane input is always element 0.
                    if (r_k == '0) r_a_row <= a_data_i;
                    else           r_a_row <= r_a_row >> DATA_W;
                end
                S_WR: begin
                    r_sat <= r_sat | w_sat_set;
                    r_i   <= r_i + DIM_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        a_rd_o    = 1'b0;
        b_rd_o    = 1'b0;
        c_rd_o    = 1'b0;
        c_wr_o    = 1'b0;
        a_addr_o  = '0;
        b_addr_o  = '0;
        c_raddr_o = '0;
        c_waddr_o = '0;
        done_o    = 1'b0;
        w_clear   = 1'b0;
        w_load    = 1'b0;
        w_step    = 1'b0;
        busy_o    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (start_i) w_next = S_RD_A;
            S_RD_A: begin
                a_rd_o    = 1'b1;
                a_addr_o  = ADDR_W'(r_i);
                c_rd_o    = r_acc;
                c_raddr_o = r_acc ? ADDR_W'(r_i) : '0;
                w_next    = S_MAC;
            end
            S_MAC: begin
                b_rd_o   = 1'b1;
                b_addr_o = ADDR_W'(r_k);
                w_clear  = (r_k == '0) && !r_acc;
                w_load   = (r_k == '0) && r_acc;
                w_step   = (r_k != '0);
                if (r_k == r_k_dim) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_step = 1'b1;
                w_next = S_WR;
            end
            S_WR: begin
                c_wr_o    = 1'b1;
                c_waddr_o = ADDR_W'(r_i);
                w_next    = (r_i == r_n) ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Columns beyond M are written as zero and never raise a saturation flag.
    always_comb begin
        c_wdata_o = '0;
        w_sat_set = '0;
        for (int j = 0; j < MAX_DIM; j++) begin
            if (r_state == S_WR && DIM_W'(j) <= r_m) begin
                c_wdata_o[j*OUT_W +: OUT_W] = get_out_elem(w_row, j);
            end
            for (int i = 0; i < MAX_DIM; i++) begin
                w_sat_set[i*MAX_DIM + j] = (r_i == DIM_W'(i)) && (DIM_W'(j) <= r_m) && w_ovf[j];
            end
        end
    end

    matmul_mac_row u_mac_row (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .i_clear  (w_clear),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_a      (r_a_row[DATA_W-1:0]),
        .i_b_row  (b_data_i),
        .i_c_row  (c_rdata_i),
        .o_row    (w_row),
        .o_ovf    (w_ovf)
    );

    assign sat_o       = r_sat;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_matmul_core.sv
// Directed bench for matmul_core: scratchpad models, write log and hand-computed result rows.
// Cycle numbering: the start edge is cycle 0, so the first RD_A is cycle 1.
module tb_matmul_core;
  import matmul_pkg::*;

  logic           clk_i = 1'b0;
  logic           reset_ni;
  logic           start_i;
  logic           acc_i;
  logic [1:0]     n_dim_i, k_dim_i, m_dim_i;
  logic [1:0]     a_addr_o, b_addr_o, c_raddr_o, c_waddr_o;
  logic           a_rd_o, b_rd_o, c_rd_o, c_wr_o;
  logic [63:0]    a_data_i = '0;
  logic [63:0]    b_data_i = '0;
  logic [127:0]   c_rdata_i = '0;
  logic [127:0]   c_wdata_o;
  logic           busy_o, done_o;
  logic [15:0]    sat_o;
  state_e         dbg_state_o;

  logic [63:0]    a_mem [4];
  logic [63:0]    b_mem [4];
  logic [127:0]   c_mem [4];
  logic [127:0]   wr_q [$];
  logic [1:0]     wa_q [$];
  logic [127:0]   exp_q [$];
  int             n_checks = 0;
  int             n_errors = 0;

  matmul_core dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .acc_i       (acc_i),
    .n_dim_i     (n_dim_i),
    .k_dim_i     (k_dim_i),
    .m_dim_i     (m_dim_i),
    .a_addr_o    (a_addr_o),
    .b_addr_o    (b_addr_o),
    .c_raddr_o   (c_raddr_o),
    .a_rd_o      (a_rd_o),
    .b_rd_o      (b_rd_o),
    .c_rd_o      (c_rd_o),
    .a_data_i    (a_data_i),
    .b_data_i    (b_data_i),
    .c_rdata_i   (c_rdata_i),
    .c_wr_o      (c_wr_o),
    .c_waddr_o   (c_waddr_o),
    .c_wdata_o   (c_wdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sat_o       (sat_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---- clock ----
  always #5 clk_i = ~clk_i;

  // ---- scratchpads: one-cycle read latency ----
  always @(posedge clk_i) begin
    if (a_rd_o) a_data_i <= a_mem[a_addr_o];
    if (b_rd_o) b_data_i <= b_mem[b_addr_o];
    if (c_rd_o) c_rdata_i <= c_mem[c_raddr_o];
  end

  // ---- write log, sampled mid-cycle ----
  always @(negedge clk_i) begin
    if (c_wr_o) begin
      wr_q.push_back(c_wdata_o);
      wa_q.push_back(c_waddr_o);
    end
  end

  function automatic logic [63:0] r16(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  function automatic logic [127:0] r32(input int e0, input int e1, input int e2, input int e3);
    return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_identity();
    for (int r = 0; r < 4; r++) begin
      a_mem[r] = 64'd1 << (16 * r);
      b_mem[r] = r16(4*r+1, 4*r+2, 4*r+3, 4*r+4);
      c_mem[r] = '0;
    end
  endtask

  task automatic push_identity_exp();
    for (int r = 0; r < 4; r++) exp_q.push_back(r32(4*r+1, 4*r+2, 4*r+3, 4*r+4));
  endtask

  // Dims and acc are scrambled after the start edge: they must only matter at start.
  task automatic run_op(input string name, input logic acc, input logic [1:0] n,
                        input logic [1:0] k, input logic [1:0] m,
                        input int p1, input int p2, input int exp_done);
    int   cyc;
    logic seen;
    wr_q.delete();
    wa_q.delete();
    acc_i = acc; n_dim_i = n; k_dim_i = k; m_dim_i = m;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    acc_i = ~acc; n_dim_i = ~n; k_dim_i = ~k; m_dim_i = ~m;
    chk({name, " busy_cyc1"}, busy_o, 1);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        start_i = (cyc == p1) || (cyc == p2);
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    start_i = 1'b0;
    chk({name, " done_cycle"}, cyc, exp_done);
    chk({name, " busy_at_done"}, busy_o, 1);
    @(posedge clk_i); #1;
    chk({name, " busy_after_done"}, busy_o, 0);
    chk({name, " done_pulse_len"}, done_o, 0);
    chk({name, " row_count"}, wr_q.size(), int'(n) + 1);
    for (int r = 0; r <= int'(n); r++) begin
      chk($sformatf("%s row%0d data", name, r), wr_q[r], exp_q[r]);
      chk($sformatf("%s row%0d addr", name, r), wa_q[r], r);
    end
    exp_q.delete();
  endtask

  initial begin
    // ---- reset ----
    reset_ni = 1'b0; start_i = 1'b0; acc_i = 1'b0;
    n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
    for (int r = 0; r < 4; r++) begin a_mem[r] = '0; b_mem[r] = '0; c_mem[r] = '0; end
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst strobes", {a_rd_o, b_rd_o, c_rd_o, c_wr_o}, 0);
    chk("rst addrs", {a_addr_o, b_addr_o, c_raddr_o, c_waddr_o}, 0);
    chk("rst wdata", c_wdata_o, 0);
    chk("rst sat", sat_o, 0);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    // ---- 4x4 identity ----
    load_identity();
    push_identity_exp();
    run_op("ident", 1'b0, 2'd3, 2'd3, 2'd3, -1, -1, 29);
    chk("ident sat", sat_o, 0);

    // ---- 2x3 * 3x2, unused columns carry garbage in B ----
    a_mem[0] = r16(1, 2, 3, 77);
    a_mem[1] = r16(4, 5, 6, 77);
    b_mem[0] = r16(7, 8, 99, 99);
    b_mem[1] = r16(9, 10, 99, 99);
    b_mem[2] = r16(11, 12, 99, 99);
    b_mem[3] = r16(55, 55, 55, 55);
    exp_q.push_back(r32(58, 64, 0, 0));
    exp_q.push_back(r32(139, 154, 0, 0));
    run_op("rect", 1'b0, 2'd1, 2'd2, 2'd1, -1, -1, 13);
    chk("rect sat", sat_o, 0);

    // ---- positive saturation ----
    for (int r = 0; r < 4; r++) begin a_mem[r] = {4{16'h7FFF}}; b_mem[r] = {4{16'h7FFF}}; end
    for (int r = 0; r < 4; r++) exp_q.push_back({4{32'h7FFFFFFF}});
    run_op("satpos", 1'b0, 2'd3, 2'd3, 2'd3, -1, -1, 29);
    chk("satpos sat", sat_o, 16'hFFFF);

    // ---- negative saturation ----
    for (int r = 0; r < 4; r++) a_mem[r] = {4{16'h8000}};
    for (int r = 0; r < 4; r++) exp_q.push_back({4{32'h80000000}});
    run_op("satneg", 1'b0, 2'd3, 2'd3, 2'd3, -1, -1, 29);
    chk("satneg sat", sat_o, 16'hFFFF);

    // ---- reset while idle clears the sticky flags ----
    reset_ni = 1'b0;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    chk("idle rst sat", sat_o, 0);

    // ---- signed accumulate: -10 + 4*(-1*-1) = -6 ----
    for (int r = 0; r < 4; r++) begin
      a_mem[r] = {4{16'hFFFF}};
      b_mem[r] = {4{16'hFFFF}};
      c_mem[r] = {4{32'hFFFFFFF6}};
      exp_q.push_back({4{32'hFFFFFFFA}});
    end
    run_op("acc", 1'b1, 2'd3, 2'd3, 2'd3, -1, -1, 29);
    chk("acc sat", sat_o, 0);

    // ---- start pulses while busy are ignored ----
    load_identity();
    push_identity_exp();
    run_op("restart", 1'b0, 2'd3, 2'd3, 2'd3, 3, 10, 29);
    chk("restart sat", sat_o, 0);

    // ---- reset during MAC of row 1 (cycles 9..12) ----
    acc_i = 1'b0; n_dim_i = 2'd3; k_dim_i = 2'd3; m_dim_i = 2'd3;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    chk("midrst in_mac", b_rd_o, 1);
    wr_q.delete();
    reset_ni = 1'b0;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    chk("midrst busy", busy_o, 0);
    chk("midrst strobes", {a_rd_o, b_rd_o, c_rd_o, c_wr_o}, 0);
    repeat (12) begin @(posedge clk_i); #1; end
    chk("midrst no_write", wr_q.size(), 0);
    chk("midrst idle_busy", busy_o, 0);

    // ---- fresh run after the reset ----
    push_identity_exp();
    run_op("fresh", 1'b0, 2'd3, 2'd3, 2'd3, -1, -1, 29);
    chk("fresh sat", sat_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matmul_core.md
# matmul_core

Parametrised matrix-multiply compute core that sits behind the APB slave of the matrix engine and replaces its fixed-size multiplier datapath. It computes C = A·B (or C = C + A·B in accumulate mode) for runtime-selectable dimensions up to max_dim, reading A, B and old C rows from the operand scratchpads over 1-cycle-latency read ports and writing C rows back. Signed saturation and per-element overflow flags are new in this generation. The APB slave drives start_i and observes busy_o and done_o.

## Interface
- data_width, 16, operand element width (signed two's complement)
- bus_width, 64, row width; max_dim = bus_width/data_width elements per row
- addr_width, 2, scratchpad row-address width; must be ≥ clog2(max_dim)

- clk_i  in  1  clock, all logic rising-edge
- reset_ni  in  1  synchronous, active-low reset
- start_i  in  1  start pulse, accepted only in IDLE
- acc_i  in  1  accumulate mode (C += A·B), sampled at start
- n_dim_i / k_dim_i / m_dim_i  in  clog2(max_dim) each  (rows of A) − 1 / (cols of A = rows of B) − 1 / (cols of B) − 1, sampled at start
- a_addr_o / b_addr_o / c_raddr_o  out  addr_width  row addresses
- a_rd_o / b_rd_o / c_rd_o  out  1  read strobes
- a_data_i / b_data_i  in  bus_width  row data, valid the cycle after the strobe
- c_rdata_i  in  2·bus_width  old C row, valid the cycle after c_rd_o
- c_wr_o  out  1  C row write strobe
- c_waddr_o  out  addr_width  C row write address
- c_wdata_o  out  2·bus_width  C row; element j at [j·2·data_width +: 2·data_width]
- busy_o  out  1  high from the cycle after start is accepted until done_o
- done_o  out  1  one-cycle completion pulse
- sat_o  out  max_dim·max_dim  sticky per-element saturation flags, bit i·max_dim+j for C[i][j]

## Operation
- Operand element j of a row at [j·data_width +: data_width]; element k of A row i multiplies B row k.
- FSM: IDLE → RD_A → MAC (K cycles) → DRAIN → WR → (RD_A for next row | DONE) → IDLE.
- IDLE: start_i=1 latches dims and acc_i, clears sat_o and row counter i=0.
- RD_A: a_rd_o=1, a_addr_o=i; in acc mode also c_rd_o=1, c_raddr_o=i.
- MAC cycle k (k=0..K−1): b_rd_o=1, b_addr_o=k. Cycle 0 captures A row and initialises accumulators (0, or sign-extended old C in acc mode). Cycle k>0 adds A[i][k−1]·B[k−1][j] for all j.
- DRAIN: adds last product term.
- WR: c_wr_o=1, c_waddr_o=i; each element clamped to signed 2·data_width range; clamped elements set their sat_o bit. Elements j > M written as zero.
- Accumulator width 2·data_width + clog2(max_dim)+1; no internal wrap.
- DONE: done_o=1 one cycle, then IDLE.
- start_i while not IDLE: ignored, no effect on dims or flags.
- Reset mid-operation: next cycle IDLE, all strobes low, no partial write; sat_o cleared.

## Timing
- Reset values: all strobes 0, addresses 0, c_wdata_o 0, busy_o 0, done_o 0, sat_o 0.
- Per C row: K+3 cycles (RD_A, K×MAC, DRAIN, WR), K = k_dim_i+1.
- start accepted at cycle 0 → done_o at cycle (N)(K+3)+1, N = n_dim_i+1.
- busy_o falls in the cycle after done_o; a new start is accepted in the done_o+1 cycle.
- Exactly one read strobe per port per cycle at most; reads never overlap writes to the same port.

## Structure
- Shared package matmul_pkg: FSM state enum, max_dim derivation, element slice/pack helper functions, saturation constants (signed max/min of 2·data_width).
- One sub-module: matmul_mac_row — max_dim parallel signed MAC lanes with clear/load/accumulate controls and saturating output stage.

## Test plan
- 4×4, acc=0, A=identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} → C rows equal B rows (32-bit elements), done_o at cycle 29, sat_o=0.
- 2×3·3×2 (n=1,k=2,m=1), A={1,2,3},{4,5,6}, B={7,8},{9,10},{11,12} → C={58,64},{139,154}, unused elements 0, done_o at cycle 13.
- Saturation: 4×4, all A,B=0x7FFF → every element 0x7FFFFFFF, sat_o all ones; A=0x8000,B=0x7FFF → 0x80000000, sat_o all ones.
- Signed/accumulate: A all −1, B all −1, old C all 0xFFFFFFF6 (−10), acc=1, k=3 → C all −6, sat_o=0.
- start_i pulsed at cycles 3 and 10 during busy → ignored; results and done_o timing identical to single-start run.
- reset_ni low for one cycle during MAC of row 1 → no c_wr_o afterwards, busy_o=0 next cycle, fresh start then completes correctly.
